// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port external SRAM arbiter: state encoding, port ids,
// halfword-select values and the debug view of the controller.
package sram_arb_pkg;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LO   = 3'd1;
   localparam logic [2:0] S_GAP1 = 3'd2;
   localparam logic [2:0] S_HI   = 3'd3;
   localparam logic [2:0] S_GAP2 = 3'd4;
   localparam logic [2:0] S_RESP = 3'd5;

   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

   // Appended below the word address to form the SRAM halfword address.
   localparam logic HW_SEL_LO = 1'b0;
   localparam logic HW_SEL_HI = 1'b1;

   typedef struct packed {
      state_t   state;
      port_id_t last_grant;
   } sram_arb_dbg_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant decision between the two masters plus the last_grant history register.
// Build option: SRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
module sram_arb_grant
   import sram_arb_pkg::*;
(
   input  logic     CLK,
   input  logic     reset,
   input  logic     m0_valid,
   input  logic     m1_valid,
   input  logic     accept,
   output port_id_t gnt_port,
   output port_id_t last_grant
);

   always_comb begin
      gnt_port = PORT0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      if (m0_valid && m1_valid)
         gnt_port = ~last_grant;
      else if (m1_valid)
         gnt_port = PORT1;
`else
      if (!m0_valid && m1_valid)
         gnt_port = PORT1;
`endif
   end

   always_ff @(posedge CLK) begin
      if (reset)
         last_grant <= PORT1;
      else if (accept)
         last_grant <= gnt_port;
   end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Two-port arbiter and sequencer for a 16-bit async SRAM: each 32-bit request becomes a
// timed low-half then high-half access. Build option SRAM_ARB_ROUND_ROBIN_EN (see sram_arb_grant).
module sram_arbiter_ctrl
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              reset,

   input  logic              m0_cmd_valid,
   output logic              m0_cmd_ready,
   input  logic              m0_cmd_write,
   input  logic [ADDR_W-2:0] m0_cmd_addr,
   input  logic [31:0]       m0_cmd_wdata,
   input  logic [3:0]        m0_cmd_mask,
   output logic              m0_rsp_valid,
   output logic [31:0]       m0_rsp_rdata,

   input  logic              m1_cmd_valid,
   output logic              m1_cmd_ready,
   input  logic              m1_cmd_write,
   input  logic [ADDR_W-2:0] m1_cmd_addr,
   input  logic [31:0]       m1_cmd_wdata,
   input  logic [3:0]        m1_cmd_mask,
   output logic              m1_rsp_valid,
   output logic [31:0]       m1_rsp_rdata,

   output logic [ADDR_W-1:0] sram_addr,
   input  logic [15:0]       sram_dat_read,
   output logic [15:0]       sram_dat_write,
   output logic              sram_dat_oe,
   output logic              sram_cs_n,
   output logic              sram_we_n,
   output logic              sram_oe_n,
   output logic              sram_lb_n,
   output logic              sram_ub_n,

   output sram_arb_dbg_t     dbg
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;
   port_id_t         gnt_port, last_grant;
   logic             accept;

   logic              cmd_write;
   logic [ADDR_W-2:0] cmd_addr;
   logic [31:0]       cmd_wdata;
   logic [3:0]        cmd_mask;
   port_id_t          cmd_port;

   logic              src_write;
   logic [ADDR_W-2:0] src_addr;
   logic [31:0]       src_wdata;
   logic [3:0]        src_mask;

   logic [15:0]       rd_lo, rd_hi;

   logic [ADDR_W-1:0] n_addr;
   logic [15:0]       n_dat_write;
   logic              n_dat_oe, n_cs_n, n_we_n, n_oe_n, n_lb_n, n_ub_n;
   logic              hi_phase;

   sram_arb_grant u_grant (
      .CLK        (CLK),
      .reset      (reset),
      .m0_valid   (m0_cmd_valid),
      .m1_valid   (m1_cmd_valid),
      .accept     (accept),
      .gnt_port   (gnt_port),
      .last_grant (last_grant)
   );

   // Handshake: a command transfers on a rising edge where valid & ready are both high.
   // ready is only offered in IDLE, to the granted port, and never while reset is high.
   assign m0_cmd_ready = (state == S_IDLE) && !reset && m0_cmd_valid && (gnt_port == PORT0);
   assign m1_cmd_ready = (state == S_IDLE) && !reset && m1_cmd_valid && (gnt_port == PORT1);
   assign accept       = m0_cmd_ready || m1_cmd_ready;

   always_comb begin
      dbg.state      = state;
      dbg.last_grant = last_grant;
   end

   // On the accepting edge the LO-phase pins are built straight from the requester's fields.
   always_comb begin
      src_write = cmd_write;
      src_addr  = cmd_addr;
      src_wdata = cmd_wdata;
      src_mask  = cmd_mask;
      if (accept) begin
         if (gnt_port == PORT1) begin
            src_write = m1_cmd_write;
            src_addr  = m1_cmd_addr;
            src_wdata = m1_cmd_wdata;
            src_mask  = m1_cmd_mask;
         end else begin
            src_write = m0_cmd_write;
            src_addr  = m0_cmd_addr;
            src_wdata = m0_cmd_wdata;
            src_mask  = m0_cmd_mask;
         end
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         S_IDLE: if (accept) begin
            next_state = S_LO;
            next_cnt   = CNT_LOAD;
         end
         S_LO: if (cnt == '0) next_state = S_GAP1;
               else           next_cnt   = cnt - 1'b1;
         S_GAP1: begin
            next_state = S_HI;
            next_cnt   = CNT_LOAD;
         end
         S_HI: if (cnt == '0) next_state = S_GAP2;
               else           next_cnt   = cnt - 1'b1;
         S_GAP2:  next_state = S_RESP;
         S_RESP:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Pin values are computed for the state being entered so they are registered outputs.
   always_comb begin
      n_addr      = sram_addr;
      n_dat_write = sram_dat_write;
      n_dat_oe    = sram_dat_oe;
      n_cs_n      = 1'b1;
      n_we_n      = 1'b1;
      n_oe_n      = 1'b1;
      n_lb_n      = 1'b1;
      n_ub_n      = 1'b1;
      hi_phase    = (next_state == S_HI);
      case (next_state)
         S_LO, S_HI: begin
            n_addr = {src_addr, hi_phase ? HW_SEL_HI : HW_SEL_LO};
            n_cs_n = 1'b0;
            if (src_write) begin
               n_dat_oe    = 1'b1;
               n_dat_write = hi_phase ? src_wdata[31:16] : src_wdata[15:0];
               n_we_n      = 1'b0;
               n_lb_n      = ~(hi_phase ? src_mask[2] : src_mask[0]);
               n_ub_n      = ~(hi_phase ? src_mask[3] : src_mask[1]);
            end else begin
               n_dat_oe = 1'b0;
               n_oe_n   = 1'b0;
               n_lb_n   = 1'b0;
               n_ub_n   = 1'b0;
            end
         end
         S_GAP1, S_GAP2: begin
            n_cs_n = 1'b0;
            n_lb_n = sram_lb_n;
            n_ub_n = sram_ub_n;
         end
         default: n_dat_oe = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         cmd_write      <= 1'b0;
         cmd_addr       <= '0;
         cmd_wdata      <= '0;
         cmd_mask       <= '0;
         cmd_port       <= PORT0;
         rd_lo          <= '0;
         rd_hi          <= '0;
         sram_addr      <= '0;
         sram_dat_write <= '0;
         sram_dat_oe    <= 1'b0;
         sram_cs_n      <= 1'b1;
         sram_we_n      <= 1'b1;
         sram_oe_n      <= 1'b1;
         sram_lb_n      <= 1'b1;
         sram_ub_n      <= 1'b1;
         m0_rsp_valid   <= 1'b0;
         m1_rsp_valid   <= 1'b0;
         m0_rsp_rdata   <= '0;
         m1_rsp_rdata   <= '0;
      end else begin
         state          <= next_state;
         cnt            <= next_cnt;
         sram_addr      <= n_addr;
         sram_dat_write <= n_dat_write;
         sram_dat_oe    <= n_dat_oe;
         sram_cs_n      <= n_cs_n;
         sram_we_n      <= n_we_n;
         sram_oe_n      <= n_oe_n;
         sram_lb_n      <= n_lb_n;
         sram_ub_n      <= n_ub_n;
         if (accept) begin
            cmd_write <= src_write;
            cmd_addr  <= src_addr;
            cmd_wdata <= src_wdata;
            cmd_mask  <= src_mask;
            cmd_port  <= gnt_port;
         end
         if (state == S_LO && cnt == '0 && !cmd_write) rd_lo <= sram_dat_read;
         if (state == S_HI && cnt == '0 && !cmd_write) rd_hi <= sram_dat_read;
         m0_rsp_valid <= (state == S_GAP2) && (cmd_port == PORT0);
         m1_rsp_valid <= (state == S_GAP2) && (cmd_port == PORT1);
         if (state == S_GAP2 && !cmd_write) begin
            if (cmd_port == PORT1) m1_rsp_rdata <= {rd_hi, rd_lo};
            else                   m0_rsp_rdata <= {rd_hi, rd_lo};
         end
      end
   end

endmodule
